debug_port_ctrl: RTL

- On-chip responder for the SystemTest debug interface. It accepts single-beat commands from a host (UART bridge or bench) and turns each one into a timed sequence on the debug port: memory read/write, register read/write, or run N instructions from a given PC.
- Sits between the host link and SystemTest's memoryoperation/registeroperation/test/resetpc pins.
- Replaces hand-timed sequencing with a deterministic ready/valid handshake.

---
 rtl/dbg_pkg.sv | 38 +++
 rtl/dbg_run_counter.sv | 45 ++++
 rtl/debug_port_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// dbg_pkg -- shared types and constants for the SystemTest debug-port responder.
//   cmd_op_e : host command opcodes (5..7 are illegal and have no enum member)
//   state_e  : debug_port_ctrl sequencer states
//   DW/RW/SW : data, register-index and CPU-state widths; CW is the 17-bit run count width
//   sat_dec  : v-1 clamped at zero, truncated to DW bits
package dbg_pkg;

   localparam int DW = 16;
   localparam int RW = 4;
   localparam int SW = 9;
   localparam int CW = DW + 1;   // N+1 for N=16'hFFFF must not wrap

   localparam logic [SW-1:0] FETCH_CODE_DEF = 9'd1;

   typedef enum logic [2:0] {
      OP_MEM_RD = 3'd0,
      OP_MEM_WR = 3'd1,
      OP_REG_RD = 3'd2,
      OP_REG_WR = 3'd3,
      OP_RUN    = 3'd4
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCESS,
      S_CHECK,
      S_RUN_RST,
      S_RUN_GO,
      S_RESP
   } state_e;

   function automatic logic [DW-1:0] sat_dec(input logic [CW-1:0] v);
      logic [CW-1:0] t;
      t = v - CW'(1);
      return (v == '0) ? '0 : t[DW-1:0];
   endfunction

endpackage

// File: rtl/dbg_run_counter.sv
// dbg_run_counter -- fetch counter plus cycle (timeout) counter for a RUN.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero both counters (held during the CPU reset cycle)
//   en         : counting window (CPU running)
//   fetch      : CPU is in its fetch state this cycle
//   target     : fetch count that completes the run
//   done       : this cycle's fetch brings the count to target
//   timeout    : this cycle is the TIMEOUT-th enabled cycle
//   seen       : fetches seen including the current cycle
module dbg_run_counter
   import dbg_pkg::*;
#(
   parameter int TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          en,
   input  logic          fetch,
   input  logic [CW-1:0] target,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] seen
);

   logic [CW-1:0] fcnt;
   logic [CW-1:0] tcnt;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         fcnt <= '0;
         tcnt <= '0;
      end else if (en) begin
         fcnt <= seen;
         tcnt <= tcnt + CW'(1);
      end
   end

   // Both flags look at the current cycle so the sequencer can stop the
   // CPU on the very cycle the condition is met.
   assign seen    = fcnt + CW'(fetch);
   assign done    = en && fetch && (seen == target);
   assign timeout = en && ((tcnt + CW'(1)) == CW'(TIMEOUT));

endmodule

// File: rtl/debug_port_ctrl.sv
// debug_port_ctrl -- turns single-beat host commands into timed sequences on
// the SystemTest debug pins (memory/register access, run N instructions).
//   host side : cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_data in,
//               rsp_valid/rsp_data/rsp_err out (one pulse per command)
//   CPU side  : test, cpu_reset, resetpc out; cpu_state in
//   memory    : memoryoperation, memorywrite, memaddress, memwritedata out; md in
//   registers : registeroperation, registerwrite, registeraddress, regwritedata out; rd in
// Optional build macro DBG_TRACE_EN adds input pc and outputs trace_valid,
// trace_pc (one-cycle pulse after each fetch while running, trace_pc = pc-1).
module debug_port_ctrl
   import dbg_pkg::*;
#(
   parameter int            ACC_LAT     = 2,
   parameter int            RUN_TIMEOUT = 65535,
   parameter logic [SW-1:0] FETCH_CODE  = FETCH_CODE_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [2:0]    cmd_op,
   input  logic [DW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_err,
   output logic          test,
   output logic          cpu_reset,
   output logic [DW-1:0] resetpc,
   input  logic [SW-1:0] cpu_state,
   output logic          memoryoperation,
   output logic          memorywrite,
   output logic [DW-1:0] memaddress,
   output logic [DW-1:0] memwritedata,
   input  logic [DW-1:0] md,
   output logic          registeroperation,
   output logic          registerwrite,
   output logic [RW-1:0] registeraddress,
   output logic [DW-1:0] regwritedata,
   input  logic [DW-1:0] rd
`ifdef DBG_TRACE_EN
   ,input  logic [DW-1:0] pc
   ,output logic          trace_valid
   ,output logic [DW-1:0] trace_pc
`endif
);

   localparam int ACW = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;

   state_e           st;
   logic [2:0]       op_q;
   logic [DW-1:0]    data_q;
   logic [ACW-1:0]   acc_cnt;

   logic             acc_last;
   logic             is_mem;
   logic             is_wr;
   logic [DW-1:0]    readback;
   logic             fetch_hit;
   logic             rc_done;
   logic             rc_timeout;
   logic [CW-1:0]    rc_seen;
   logic [CW-1:0]    run_target;

   assign acc_last   = (acc_cnt == ACW'(ACC_LAT - 1));
   assign is_mem     = (op_q == OP_MEM_RD) || (op_q == OP_MEM_WR);
   assign is_wr      = (op_q == OP_MEM_WR) || (op_q == OP_REG_WR);
   assign readback   = is_mem ? md : rd;
   assign fetch_hit  = (cpu_state == FETCH_CODE);
   assign run_target = {1'b0, data_q} + CW'(1);

   dbg_run_counter #(
      .TIMEOUT (RUN_TIMEOUT)
   ) u_run_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (st == S_RUN_RST),
      .en      (st == S_RUN_GO),
      .fetch   (fetch_hit),
      .target  (run_target),
      .done    (rc_done),
      .timeout (rc_timeout),
      .seen    (rc_seen)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st                <= S_IDLE;
         cmd_ready         <= 1'b1;
         op_q              <= '0;
         data_q            <= '0;
         acc_cnt           <= '0;
         rsp_valid         <= 1'b0;
         rsp_data          <= '0;
         rsp_err           <= 1'b0;
         test              <= 1'b0;
         cpu_reset         <= 1'b0;
         resetpc           <= '0;
         memoryoperation   <= 1'b0;
         memorywrite       <= 1'b0;
         memaddress        <= '0;
         memwritedata      <= '0;
         registeroperation <= 1'b0;
         registerwrite     <= 1'b0;
         registeraddress   <= '0;
         regwritedata      <= '0;
`ifdef DBG_TRACE_EN
         trace_valid       <= 1'b0;
`endif
      end else begin
         rsp_valid <= 1'b0;
`ifdef DBG_TRACE_EN
         trace_valid <= (st == S_RUN_GO) && fetch_hit;
`endif
         case (st)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  op_q      <= cmd_op;
                  data_q    <= cmd_data;
                  acc_cnt   <= '0;
                  case (cmd_op)
                     OP_MEM_RD, OP_MEM_WR: begin
                        memoryoperation <= 1'b1;
                        memorywrite     <= (cmd_op == OP_MEM_WR);
                        memaddress      <= cmd_addr;
                        memwritedata    <= cmd_data;
                        st              <= S_ACCESS;
                     end
                     OP_REG_RD, OP_REG_WR: begin
                        registeroperation <= 1'b1;
                        registerwrite     <= (cmd_op == OP_REG_WR);
                        registeraddress   <= cmd_addr[RW-1:0];
                        regwritedata      <= cmd_data;
                        st                <= S_ACCESS;
                     end
                     OP_RUN: begin
                        if (cmd_data == '0) begin
                           // Zero-length run: answer without touching the CPU.
                           rsp_valid <= 1'b1;
                           rsp_data  <= '0;
                           rsp_err   <= 1'b0;
                           st        <= S_RESP;
                        end else begin
                           cpu_reset <= 1'b1;
                           resetpc   <= cmd_addr;
                           st        <= S_RUN_RST;
                        end
                     end
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        st        <= S_RESP;
                     end
                  endcase
               end
            end

            S_ACCESS: begin
               if (acc_last) begin
                  if (is_wr) begin
                     // Drop the strobe but keep the select so readback is valid.
                     memorywrite   <= 1'b0;
                     registerwrite <= 1'b0;
                     st            <= S_CHECK;
                  end else begin
                     memoryoperation   <= 1'b0;
                     registeroperation <= 1'b0;
                     rsp_valid         <= 1'b1;
                     rsp_data          <= readback;
                     rsp_err           <= 1'b0;
                     st                <= S_RESP;
                  end
               end else begin
                  acc_cnt <= acc_cnt + ACW'(1);
               end
            end

            S_CHECK: begin
               // Index-0 register writes land here too; a hardwired r0
               // simply shows up as a readback mismatch.
               memoryoperation   <= 1'b0;
               registeroperation <= 1'b0;
               rsp_valid         <= 1'b1;
               rsp_data          <= readback;
               rsp_err           <= (readback != data_q);
               st                <= S_RESP;
            end

            S_RUN_RST: begin
               cpu_reset <= 1'b0;
               test      <= 1'b1;
               st        <= S_RUN_GO;
            end

            S_RUN_GO: begin
               // Completion wins over a timeout landing on the same cycle.
               if (rc_done) begin
                  test      <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= data_q;
                  rsp_err   <= 1'b0;
                  st        <= S_RESP;
               end else if (rc_timeout) begin
                  test      <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_data  <= sat_dec(rc_seen);
                  rsp_err   <= 1'b1;
                  st        <= S_RESP;
               end
            end

            S_RESP: begin
               cmd_ready <= 1'b1;
               st        <= S_IDLE;
            end

            default: begin
               cmd_ready <= 1'b1;
               st        <= S_IDLE;
            end
         endcase
      end
   end

`ifdef DBG_TRACE_EN
   // The pulse follows the fetch by a cycle, by which time pc has moved on.
   assign trace_pc = pc - DW'(1);
`endif

endmodule
